// File: rtl/load_extend_ctrl.sv
// load_extend_ctrl: load-path sequencer. It issues one word read, selects the
// byte or halfword lane, and sign- or zero-extends the data to 32 bits.
// Ports: clk, reset_n; start/load_type/addr from control; mem_rd/mem_addr/
// mem_rdata to and from data memory; busy/done/err/result/load_count out.
// Optional: define LOAD_STATS_EN to count completed good loads.
module load_extend_ctrl #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  load_type,
  input  logic [31:0] addr,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] result,
  output logic [15:0] load_count
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t      state;
  state_t      state_nx;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nx;
  logic [2:0]  typ;
  logic [1:0]  a_lo;
  logic        bad;
  logic        accept;
  logic        capture;
  logic        is_byte;
  logic        is_half;
  logic        uns;
  logic [7:0]  byte_l;
  logic [15:0] half_l;
  logic [31:0] ext;

  assign accept  = (state == IDLE) && start;
  assign capture = (state == WAIT) && (cnt == 4'd0);

  // Invalid type or misalignment, judged on the live request.
  always_comb begin
    bad = 1'b1;
    unique case (load_type)
      3'b000, 3'b100: bad = 1'b0;
      3'b001, 3'b101: bad = addr[0];
      3'b010:         bad = |addr[1:0];
      default:        bad = 1'b1;
    endcase
  end

  assign is_byte = (typ[1:0] == 2'b00);
  assign is_half = (typ[1:0] == 2'b01);
  assign uns     = typ[2];

  assign byte_l = mem_rdata[{a_lo, 3'b000} +: 8];
  assign half_l = a_lo[1] ? mem_rdata[31:16]
                          : mem_rdata[15:0];

  always_comb begin
    ext = mem_rdata;
    unique case (1'b1)
      is_byte: ext = {{24{byte_l[7] & ~uns}},
                      byte_l};
      is_half: ext = {{16{half_l[15] & ~uns}},
                      half_l};
      default: ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (start)
          state_nx = bad ? DONE : ISSUE;
      end
      ISSUE: begin
        state_nx = WAIT;
        cnt_nx   = LAT_M1;
      end
      WAIT: begin
        if (cnt == 4'd0)
          state_nx = DONE;
        else
          cnt_nx = cnt - 4'd1;
      end
      DONE: state_nx = IDLE;
    endcase
  end

  // Strobes decode from the async-reset state, so reset kills them at once.
  assign mem_rd = (state == ISSUE);
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      typ      <= 3'd0;
      a_lo     <= 2'd0;
      mem_addr <= 32'd0;
      err      <= 1'b0;
      result   <= 32'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        typ      <= load_type;
        a_lo     <= addr[1:0];
        mem_addr <= {addr[31:2], 2'b00};
        err      <= bad;
        if (bad)
          result <= 32'd0;
      end
      if (capture)
        result <= ext;
    end
  end

`ifdef LOAD_STATS_EN
  logic [15:0] stat_q;

  // Bumped on the edge entering DONE, so it is current while done is high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      stat_q <= 16'h0000;
    else if (capture && (stat_q != 16'hFFFF))
      stat_q <= stat_q + 16'h0001;
  end

  assign load_count = stat_q;
`else
  assign load_count = 16'h0000;
`endif

endmodule

// File: doc/load_extend_ctrl.md
Name: load_extend_ctrl

Overview:
- Multicycle sequencer for the load path: issues one word read to data memory, selects the byte or halfword lane, and sign- or zero-extends it to 32 bits.
- Replaces the ad-hoc control-unit sequencing of the 16→32 and 1→32 extenders on loads.
- Sits between the main control FSM (start/done handshake) and the memory port; output goes to the MDR/writeback mux.

Parameters:
MEM_LAT, 1, memory read latency in cycles from mem_rd to valid mem_rdata (legal range 1..15)

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous reset, active-low
start  input  1  request a load; sampled only in IDLE
load_type  input  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; all other values are invalid
addr  input  32  byte address; captured with start
mem_rd  output  1  read strobe, high for exactly one cycle per access
mem_addr  output  32  word-aligned address, {addr[31:2],2'b00}
mem_rdata  input  32  memory read data
busy  output  1  high in every state except IDLE
done  output  1  one-cycle completion pulse
err  output  1  misaligned access or invalid type; valid while done=1
result  output  32  extended load data; held until the next completion
load_count  output  16  completed-load counter (see Optional Feature)

Behaviour:
- Reset (async, reset_n=0): state=IDLE; mem_rd=0, mem_addr=0, busy=0, done=0, err=0, result=0, load_count=0. mem_rd drops immediately, including when reset is asserted mid-access.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE, start=1: latch addr and load_type.
  - Invalid type, LH/LHU with addr[0]=1, or LW with addr[1:0]!=0 → DONE with err=1 and result=0. No memory access is made.
  - Otherwise → ISSUE.
- ISSUE (1 cycle): mem_rd=1, mem_addr driven. → WAIT with counter=MEM_LAT-1.
- WAIT: counter decrements each cycle. When counter=0, capture the extended data into result and go to DONE. mem_addr holds its value through WAIT.
- DONE (1 cycle): done=1, err valid. → IDLE.
- Latency:
  - Good access: done is high in the cycle after MEM_LAT+2 rising edges counted from the edge that samples start. MEM_LAT=1 gives 3 cycles.
  - Error case: 1 cycle.
- Lane select is little-endian:
  - Byte: mem_rdata[8*a[1:0] +: 8].
  - Half: a[1] ? mem_rdata[31:16] : mem_rdata[15:0].
  - Word: mem_rdata.
- Extension:
  - LB/LH replicate bit 7/15 into the upper bits.
  - LBU/LHU zero-fill the upper bits.
  - LW passes through.
- Back-to-back: start in the DONE cycle is ignored. A new start is accepted in the IDLE cycle after done, so the minimum issue spacing is MEM_LAT+3 cycles.
- start while busy=1: ignored. It has no effect on the latched addr/type.
- err is cleared when the next start is accepted. result changes only in the cycle done is asserted.

Optional Feature:
- Macro: LOAD_STATS_EN.
- Defined: load_count increments by 1 at every done with err=0. It saturates at 16'hFFFF and is reset to 0 by reset_n.
- Undefined: no counter logic; load_count is tied to 16'h0000.

Test Plan:
- MEM_LAT=1; start, LB, addr=0x103, mem_rdata=0x85112233 → mem_rd one cycle with mem_addr=0x100; done 3 cycles after start; result=0xFFFFFF85, err=0.
- LBU, addr=0x103, same data → result=0x00000085. LHU, addr=0x102 → 0x00008511. LH, addr=0x100, data=0x0000F00F → 0xFFFFF00F.
- LW, addr=0x102 → done on the next cycle, err=1, result=0, mem_rd never asserted. load_type=3'b111 → same response.
- MEM_LAT=4; LW, addr=0x40, data=0xDEADBEEF → done 6 cycles after start, result=0xDEADBEEF. start pulsed during WAIT → ignored, no second mem_rd.
- reset_n dropped during WAIT → mem_rd, busy and done go to 0 immediately, state=IDLE; a new LW after release completes normally.
- LOAD_STATS_EN defined: 3 good loads plus 1 misaligned → load_count=3. Counter preloaded to 16'hFFFF, then 1 good load → stays 16'hFFFF. LOAD_STATS_EN undefined → load_count=0 throughout.
